// File: rtl/uart_rx.sv
// Memory-mapped UART receiver: synchroniser, frame FSM, receive FIFO.
// Status is polled by software; RX_DATA reads pop the FIFO head.
module uart_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BAUD_W      = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  input  logic        Rx_in,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic rx_s;
  logic rx_prev;

  assign rx_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], Rx_in};
      rx_prev <= rx_s;
    end
  end

  logic sel_data, sel_ctrl, sel_baud, sel_stat;

  assign sel_data = (addr == 32'h10);
  assign sel_ctrl = (addr == 32'h14);
  assign sel_baud = (addr == 32'h18);
  assign sel_stat = (addr == 32'h1C);

  logic [2:0]        ctrl_q;
  logic [BAUD_W-1:0] baud_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      baud_q <= '0;
    end else begin
      if (wr_en && sel_ctrl) ctrl_q <= wdata[2:0];
      if (wr_en && sel_baud) baud_q <= wdata[BAUD_W-1:0];
    end
  end

  logic active;
  assign active = ctrl_q[0] && (baud_q >= BAUD_W'(2));

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] div_q, div_d;
  logic              two_q, two_d;
  logic              odd_q, odd_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        idx_q, idx_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              push;
  logic              tick;
  logic [BAUD_W-1:0] reload;

  assign tick   = (cnt_q == '0);
  assign reload = div_q - BAUD_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      two_q   <= 1'b0;
      odd_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      two_q   <= two_d;
      odd_q   <= odd_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    two_d   = two_q;
    odd_d   = odd_q;
    data_d  = data_q;
    idx_d   = idx_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (!active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            div_d   = baud_q;
            two_d   = ctrl_q[1];
            odd_d   = ctrl_q[2];
            cnt_d   = (baud_q >> 1) - BAUD_W'(1);
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = START;
          end
        end
        START: begin
          if (!tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
          end else if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = reload;
            idx_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
          end else begin
            data_d[idx_q] = rx_s;
            cnt_d = reload;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = PARITY;
          end
        end
        PARITY: begin
          if (!tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
          end else begin
            // odd parity expects the inverted XOR
            if (rx_s != ((^data_q) ^ odd_q)) perr_d = 1'b1;
            cnt_d   = reload;
            state_d = STOP1;
          end
        end
        STOP1: begin
          if (!tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
          end else begin
            if (!rx_s) ferr_d = 1'b1;
            if (two_q) begin
              cnt_d   = reload;
              state_d = STOP2;
            end else begin
              push    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        STOP2: begin
          if (!tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
          end else begin
            if (!rx_s) ferr_d = 1'b1;
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, not_empty, pop, push_ok;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign not_empty = (count != '0);
  assign pop       = rd_en && sel_data && not_empty;
  assign push_ok   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= data_q;
  end

  logic [2:0] flags;
  logic [2:0] flag_set;
  logic [2:0] flag_clr;

  assign flag_set = {push && ferr_d, push && perr_d, push && !push_ok};
  assign flag_clr = (wr_en && sel_stat) ? wdata[3:1] : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= (flags & ~flag_clr) | flag_set;
  end

  logic [2:0] count3;
  assign count3 = 3'(count);

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_data: if (not_empty) rdata = {24'b0, mem[rptr]};
        sel_ctrl: rdata = {29'b0, ctrl_q};
        sel_baud: rdata = {{(32-BAUD_W){1'b0}}, baud_q};
        sel_stat: rdata = {25'b0, count3, flags, not_empty};
        default:  rdata = '0;
      endcase
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:BAUD_W];

endmodule
